// File: rtl/fifo_pkg.sv
// Shared constants and types for the 8x16 FIFO read path.
package fifo_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } rd_state_e;

    typedef logic [1:0] buf_cnt_t;

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry ring buffer that holds captured FIFO words and presents the head
// as the output stream word.
module reader_skid_buf #(
    parameter int unsigned DATA_W = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               push,
    input  logic [DATA_W-1:0]  push_data,
    input  logic               pop,
    output fifo_pkg::buf_cnt_t buf_cnt,
    output logic               m_valid,
    output logic [DATA_W-1:0]  m_data
);
    import fifo_pkg::*;

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    buf_cnt_t          cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign buf_cnt = cnt;
    assign m_valid = (cnt != '0);
    assign m_data  = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the 8x16 FIFO: credit-based reads into a 2-entry
// buffer, valid/ready output with packet framing. READER_STATS_EN adds counters.
module fifo_stream_reader #(
    parameter int unsigned DATA_W  = fifo_pkg::DATA_W,
    parameter int unsigned PKT_LEN = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              f_empty,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_enb,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              underrun_err
`ifdef READER_STATS_EN
    ,
    output logic [15:0]       word_cnt,
    output logic [15:0]       stall_cnt
`endif
);
    import fifo_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    rd_state_e  state;
    logic       inflight;
    logic       pop;
    buf_cnt_t   buf_cnt;
    logic [7:0] pkt_cnt;
    logic [2:0] occupancy;

    // Words held plus the one in flight, less the one leaving this cycle;
    // keeping this below 2 guarantees the buffer never overflows.
    assign pop       = m_valid & m_ready;
    assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd_enb    = (state == RUN) & ~f_empty & (occupancy < 3'd2);
    assign m_last    = m_valid & (pkt_cnt == LAST_IDX);
    assign busy      = (state != IDLE) | inflight | (buf_cnt != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            inflight     <= 1'b0;
            pkt_cnt      <= '0;
            underrun_err <= 1'b0;
        end else begin
            inflight <= rd_enb;
            if (rd_enb && f_empty) begin
                underrun_err <= 1'b1;
            end
            if (pop) begin
                pkt_cnt <= m_last ? '0 : pkt_cnt + 8'd1;
            end
            case (state)
                IDLE: if (en) state <= RUN;
                RUN:  if (!en) state <= STOP;
                STOP: begin
                    if (en) begin
                        state <= RUN;
                    end else if (!inflight && buf_cnt == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    reader_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid_buf (
        .clk       (clk),
        .resetn    (resetn),
        .push      (inflight),
        .push_data (rd_data),
        .pop       (pop),
        .buf_cnt   (buf_cnt),
        .m_valid   (m_valid),
        .m_data    (m_data)
    );

`ifdef READER_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop && word_cnt != '1) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (m_valid && !m_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: two reader lanes (PKT_LEN 8 and 3) on private FIFO models,
// shared stimulus, per-lane monitors checking order, framing, hold and credit.
module tb_fifo_stream_reader;

    localparam int unsigned DW = 16;
    localparam int          NL = 2;

    logic          clk     = 1'b0;
    logic          resetn  = 1'b0;
    logic          en      = 1'b0;
    logic          m_ready = 1'b0;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;

    int n_chk = 0;
    int n_err = 0;

    logic [NL-1:0] v_rd_enb, v_valid, v_last, v_busy, v_uerr, v_empty;
    logic [DW-1:0] v_data [NL];
    int unsigned   v_fqn  [NL];
    int unsigned   v_expn [NL];
    int unsigned   v_acc  [NL];
`ifdef READER_STATS_EN
    logic [15:0]   v_word [NL];
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input int lane,
                         input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s lane%0d: got %h, required %h (t=%0t)", name, lane, act, req, $time);
        end
    endtask

    for (genvar L = 0; L < NL; L++) begin : g_lane
        localparam int unsigned PLEN = (L == 0) ? 8 : 3;

        logic          f_empty = 1'b1;
        logic [DW-1:0] rd_data = '0;
        logic          rd_enb, m_valid, m_last, busy, underrun_err;
        logic [DW-1:0] m_data;
        logic [DW-1:0] fq    [$];
        logic [DW-1:0] exp_q [$];
        int unsigned   fq_n = 0, exp_n = 0, n_reads = 0, rd_base = 0;
        int unsigned   n_acc = 0, acc_total = 0, pkt_pos = 0, outstanding = 0;
        logic          prev_stall = 1'b0, pop_now;
        logic [DW-1:0] prev_data = '0, exp_word;
`ifdef READER_STATS_EN
        logic [15:0]   word_cnt, stall_cnt;
        int unsigned   w_model = 0, s_model = 0;
`endif

        fifo_stream_reader #(
            .DATA_W  (DW),
            .PKT_LEN (PLEN)
        ) dut (
            .clk          (clk),
            .resetn       (resetn),
            .en           (en),
            .f_empty      (f_empty),
            .rd_data      (rd_data),
            .rd_enb       (rd_enb),
            .m_valid      (m_valid),
            .m_data       (m_data),
            .m_last       (m_last),
            .m_ready      (m_ready),
            .busy         (busy),
            .underrun_err (underrun_err)
`ifdef READER_STATS_EN
            ,
            .word_cnt     (word_cnt),
            .stall_cnt    (stall_cnt)
`endif
        );

        assign v_rd_enb[L] = rd_enb;
        assign v_valid[L]  = m_valid;
        assign v_last[L]   = m_last;
        assign v_busy[L]   = busy;
        assign v_uerr[L]   = underrun_err;
        assign v_empty[L]  = f_empty;
        assign v_data[L]   = m_data;
        assign v_fqn[L]    = fq_n;
        assign v_expn[L]   = exp_n;
        assign v_acc[L]    = acc_total;
`ifdef READER_STATS_EN
        assign v_word[L]   = word_cnt;
`endif

        // Behavioural FIFO: registered read data, empty flag from occupancy.
        always @(posedge clk) begin
            if (rd_enb) begin
                n_reads++;
                if (fq.size() != 0) rd_data <= fq.pop_front();
            end
            if (wr_en) fq.push_back(wr_data);
            fq_n = fq.size();
            f_empty <= (fq.size() == 0);
        end

        always @(negedge clk or negedge resetn) begin
            if (!resetn) begin
                // The FIFO survives a reader reset; anything already taken out is lost.
                exp_q = fq;
                exp_n = exp_q.size();
                rd_base = n_reads;
                n_acc = 0;
                pkt_pos = 0;
                prev_stall = 1'b0;
`ifdef READER_STATS_EN
                w_model = 0;
                s_model = 0;
`endif
            end else begin
                if (wr_en) exp_q.push_back(wr_data);
                pop_now = m_valid && m_ready;
                outstanding = n_reads - rd_base - n_acc;
                if (prev_stall) begin
                    check("hold_valid", L, m_valid, 1);
                    check("hold_data", L, m_data, prev_data);
                end
                if (rd_enb) begin
                    check("credit", L, (outstanding - pop_now < 2), 1);
                    check("read_nonempty", L, f_empty, 0);
                end
                check("underrun_err", L, underrun_err, 0);
                check("m_last", L, m_last, m_valid && (pkt_pos == PLEN - 1));
`ifdef READER_STATS_EN
                check("word_cnt", L, word_cnt, w_model);
                check("stall_cnt", L, stall_cnt, s_model);
                if (pop_now && w_model < 65535) w_model++;
                if (m_valid && !m_ready && s_model < 65535) s_model++;
`endif
                if (pop_now) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_word", L, 1, 0);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check("m_data", L, m_data, exp_word);
                    end
                    pkt_pos = (pkt_pos + 1) % PLEN;
                    n_acc++;
                    acc_total++;
                end
                exp_n = exp_q.size();
                prev_stall = m_valid && !m_ready;
                prev_data = m_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            wr_data = base + DW'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic go_idle();
        int cyc;
        cyc = 0;
        en = 1'b0;
        while (v_busy != '0 && cyc < 100) begin
            tick();
            cyc++;
        end
        for (int i = 0; i < NL; i++) check("drain_to_idle", i, v_busy[i], 0);
    endtask

    initial begin
        int unsigned base_acc [NL];
        int          cnt;
        logic [3:0]  pat;

        // Reset values, then RUN with an empty FIFO.
        en = 1'b1;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            check("rst_rd_enb", i, v_rd_enb[i], 0);
            check("rst_m_valid", i, v_valid[i], 0);
            check("rst_m_data", i, v_data[i], 0);
            check("rst_m_last", i, v_last[i], 0);
            check("rst_busy", i, v_busy[i], 0);
            check("rst_underrun", i, v_uerr[i], 0);
        end
        tick();
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            check("empty_rd_enb", i, v_rd_enb[i], 0);
            check("empty_m_valid", i, v_valid[i], 0);
            check("run_busy", i, v_busy[i], 1);
        end

        // Pre-filled FIFO, full-rate drain: 2-cycle read latency, 8 back-to-back words.
        go_idle();
        write_words(16'hA001, 8);
        tick();
        en = 1'b1;
        @(negedge clk);
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < NL; i++) check("latency_early", i, v_valid[i], 0);
        end
        repeat (8) begin
            @(negedge clk);
            for (int i = 0; i < NL; i++) check("burst_valid", i, v_valid[i], 1);
        end
        @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            check("burst_end_valid", i, v_valid[i], 0);
            check("burst_f_empty", i, v_empty[i], 1);
        end

        // Back-pressure pattern 1,0,0,1 while the FIFO is being filled.
        tick();
        pat = 4'b1001;
        for (int k = 0; k < 40; k++) begin
            m_ready = pat[k % 4];
            wr_en = (k < 8);
            wr_data = 16'hB001 + DW'(k);
            tick();
        end
        wr_en = 1'b0;
        m_ready = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < NL; i++) check("bp_drained", i, v_expn[i], 0);

        // Drop en right after the 3rd accepted word: exactly 2 more follow.
        go_idle();
        write_words(16'hC001, 8);
        tick();
        for (int i = 0; i < NL; i++) base_acc[i] = v_acc[i];
        en = 1'b1;
        cnt = 0;
        for (int k = 0; k < 50 && cnt < 3; k++) begin
            @(negedge clk);
            if (v_valid[0] && m_ready) cnt++;
        end
        en = 1'b0;
        check("third_accept_seen", 0, cnt, 3);
        go_idle();
        for (int i = 0; i < NL; i++) begin
            check("stop_delivered", i, v_acc[i] - base_acc[i], 5);
            check("stop_fifo_left", i, v_fqn[i], 3);
        end

        // Randomised traffic, back-pressure and en toggling.
        for (int k = 0; k < 800; k++) begin
            en = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            wr_en = ($urandom_range(0, 1) != 0) && v_fqn[0] < 8 && v_fqn[1] < 8;
            wr_data = DW'($urandom);
            tick();
        end
        wr_en = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;
        repeat (30) tick();
        for (int i = 0; i < NL; i++) check("random_drained", i, v_expn[i], 0);

        // Asynchronous reset with a word held and another in flight.
        go_idle();
        write_words(16'hD001, 4);
        m_ready = 1'b0;
        en = 1'b1;
        cnt = 0;
        while (!v_valid[0] && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("pre_reset_valid", 0, v_valid[0], 1);
        #2;
        resetn = 1'b0;
        #1;
        for (int i = 0; i < NL; i++) begin
            check("async_m_valid", i, v_valid[i], 0);
            check("async_rd_enb", i, v_rd_enb[i], 0);
            check("async_busy", i, v_busy[i], 0);
            check("async_fifo_left", i, v_fqn[i], 2);
`ifdef READER_STATS_EN
            check("async_word_cnt", i, v_word[i], 0);
`endif
        end
        tick();
        tick();
        resetn = 1'b1;
        m_ready = 1'b1;
        repeat (20) tick();
        go_idle();
        for (int i = 0; i < NL; i++) check("final_drained", i, v_expn[i], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
